// File: rtl/apb_slave_splitter.sv
// -----------------------------------------------------------------------------
// apb_slave_splitter
//
// Purpose:
//   APB3 interconnect that fans one upstream APB slave port out to C_CHANNELS
//   downstream register banks. Each bank owns a fixed window of
//   2^C_SLOT_BITS bytes. The slot field directly above the window offset
//   selects the bank. Every downstream transfer is re-timed through a
//   registered FSM. If an access is unmapped, or a bank never raises its
//   ready, the upstream side still gets a PSLVERR response. A hung sub-block
//   therefore cannot hang the host bus.
//
// Ports:
//   CLK, nRST        clock (rising edge) and asynchronous active-low reset
//   S_PSEL..S_PWDATA upstream APB request
//   S_PRDATA         upstream read data, valid while S_PREADY=1
//   S_PREADY         upstream ready, high only in the response cycle
//   S_PSLVERR        upstream error, valid while S_PREADY=1
//   M_PSEL           one-hot downstream select
//   M_PENABLE        downstream enable, broadcast
//   M_PWRITE         downstream direction, broadcast
//   M_PADDR          in-window downstream address
//   M_PWDATA         downstream write data, broadcast
//   M_PRDATA         packed downstream read data, slave i at [32*i +: 32]
//   M_PREADY         per-slave ready
//   M_PSLVERR        per-slave error
//   ERR              one-cycle pulse on every error response
// -----------------------------------------------------------------------------
module apb_slave_splitter #(
    parameter int C_CHANNELS  = 4,
    parameter int C_ADDR_BITS = 16,
    parameter int C_SLOT_BITS = 12,
    parameter int C_TIMEOUT   = 256
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     S_PSEL,
    input  logic                     S_PENABLE,
    input  logic                     S_PWRITE,
    input  logic [C_ADDR_BITS-1:0]   S_PADDR,
    input  logic [31:0]              S_PWDATA,
    output logic [31:0]              S_PRDATA,
    output logic                     S_PREADY,
    output logic                     S_PSLVERR,
    output logic [C_CHANNELS-1:0]    M_PSEL,
    output logic                     M_PENABLE,
    output logic                     M_PWRITE,
    output logic [C_SLOT_BITS-1:0]   M_PADDR,
    output logic [31:0]              M_PWDATA,
    input  logic [32*C_CHANNELS-1:0] M_PRDATA,
    input  logic [C_CHANNELS-1:0]    M_PREADY,
    input  logic [C_CHANNELS-1:0]    M_PSLVERR,
    output logic                     ERR
);

    localparam int SEL_BITS   = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1;
    localparam int UPPER_BITS = C_ADDR_BITS - C_SLOT_BITS - SEL_BITS;
    localparam int CNT_BITS   = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [SEL_BITS:0] CH_LIMIT = (SEL_BITS + 1)'(C_CHANNELS);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                  state_q;
    logic [SEL_BITS-1:0]     slot_q;
    logic                    abort_q;
    logic [CNT_BITS-1:0]     waitCnt_q;
    logic [C_CHANNELS-1:0]   mPsel_q;
    logic                    mPenable_q;
    logic                    mPwrite_q;
    logic [C_SLOT_BITS-1:0]  mPaddr_q;
    logic [31:0]             mPwdata_q;
    logic [31:0]             sPrdata_q;
    logic                    sPready_q;
    logic                    sPslverr_q;
    logic                    err_q;

    logic [SEL_BITS-1:0]     slotDec;
    logic                    upperHit;
    logic                    addrMapped;
    logic [C_CHANNELS-1:0]   slotOneHot;
    logic                    selReady;
    logic                    selErr;
    logic [31:0]             selRdata;
    logic                    timeoutHit;

    // Address decode of the live upstream request. An access is unmapped
    // if any address bit above the slot field is set, or if the slot number
    // has no bank behind it.
    assign slotDec = S_PADDR[C_SLOT_BITS +: SEL_BITS];

    generate
        if (UPPER_BITS > 0) begin : gUpper
            assign upperHit = |S_PADDR[C_ADDR_BITS-1 : C_SLOT_BITS+SEL_BITS];
        end else begin : gNoUpper
            assign upperHit = 1'b0;
        end
    endgenerate

    assign addrMapped = !upperHit && ({1'b0, slotDec} < CH_LIMIT);

    // Build the one-hot select from the decoded slot.
    always_comb begin
        slotOneHot = '0;
        for (int i = 0; i < C_CHANNELS; i++) begin
            slotOneHot[i] = (slotDec == SEL_BITS'(i));
        end
    end

    // Route the latched slave's response signals. A compare loop is used
    // instead of a computed part-select to keep index widths exact.
    always_comb begin
        selReady = 1'b0;
        selErr   = 1'b0;
        selRdata = '0;
        for (int i = 0; i < C_CHANNELS; i++) begin
            if (slot_q == SEL_BITS'(i)) begin
                selReady = M_PREADY[i];
                selErr   = M_PSLVERR[i];
                selRdata = M_PRDATA[32*i +: 32];
            end
        end
    end

    // The counter holds the number of ACCESS cycles already spent waiting.
    // Reaching C_TIMEOUT-1 means the current cycle is the last allowed one.
    assign timeoutHit = (C_TIMEOUT != 0) && (waitCnt_q == CNT_BITS'(C_TIMEOUT - 1));

    // Transfer FSM. All outputs are registered here. S_PREADY and ERR
    // default low every cycle, so they can only pulse for the single RESP
    // cycle. If the host drops PSEL mid-transfer, abort_q is set. The
    // downstream side still finishes its handshake, but nothing is reported
    // upstream.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            abort_q    <= 1'b0;
            waitCnt_q  <= '0;
            mPsel_q    <= '0;
            mPenable_q <= 1'b0;
            mPwrite_q  <= 1'b0;
            mPaddr_q   <= '0;
            mPwdata_q  <= '0;
            sPrdata_q  <= '0;
            sPready_q  <= 1'b0;
            sPslverr_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sPready_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    sPrdata_q  <= '0;
                    sPslverr_q <= 1'b0;
                    if (S_PSEL && !S_PENABLE) begin
                        if (addrMapped) begin
                            state_q    <= SETUP;
                            slot_q     <= slotDec;
                            abort_q    <= 1'b0;
                            waitCnt_q  <= '0;
                            mPsel_q    <= slotOneHot;
                            mPwrite_q  <= S_PWRITE;
                            mPaddr_q   <= S_PADDR[C_SLOT_BITS-1:0];
                            mPwdata_q  <= S_PWDATA;
                        end else begin
                            state_q    <= RESP;
                            sPready_q  <= 1'b1;
                            sPslverr_q <= 1'b1;
                            err_q      <= 1'b1;
                        end
                    end
                end

                SETUP: begin
                    state_q    <= ACCESS;
                    mPenable_q <= 1'b1;
                    if (!S_PSEL) begin
                        abort_q <= 1'b1;
                    end
                end

                ACCESS: begin
                    if (selReady || timeoutHit) begin
                        mPsel_q    <= '0;
                        mPenable_q <= 1'b0;
                        mPwrite_q  <= 1'b0;
                        mPaddr_q   <= '0;
                        mPwdata_q  <= '0;
                        waitCnt_q  <= '0;
                        abort_q    <= 1'b0;
                        if (abort_q || !S_PSEL) begin
                            state_q <= IDLE;
                        end else begin
                            state_q   <= RESP;
                            sPready_q <= 1'b1;
                            // A ready slave wins over a timeout in the same cycle.
                            if (selReady) begin
                                sPrdata_q  <= mPwrite_q ? 32'h0 : selRdata;
                                sPslverr_q <= selErr;
                                err_q      <= selErr;
                            end else begin
                                sPrdata_q  <= '0;
                                sPslverr_q <= 1'b1;
                                err_q      <= 1'b1;
                            end
                        end
                    end else begin
                        waitCnt_q <= waitCnt_q + CNT_BITS'(1);
                        if (!S_PSEL) begin
                            abort_q <= 1'b1;
                        end
                    end
                end

                RESP: begin
                    state_q    <= IDLE;
                    sPrdata_q  <= '0;
                    sPslverr_q <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign S_PRDATA  = sPrdata_q;
    assign S_PREADY  = sPready_q;
    assign S_PSLVERR = sPslverr_q;
    assign ERR       = err_q;
    assign M_PSEL    = mPsel_q;
    assign M_PENABLE = mPenable_q;
    assign M_PWRITE  = mPwrite_q;
    assign M_PADDR   = mPaddr_q;
    assign M_PWDATA  = mPwdata_q;

endmodule

// File: tb/tb_apb_slave_splitter.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_splitter
//
// Purpose:
//   Bench for apb_slave_splitter. The main instance has 4 channels and a
//   short timeout. A second, 3-channel instance covers a slot number that
//   has no bank behind it. A behavioural slave answers on whichever channel
//   is selected, using wait states, error and data chosen per transfer.
//   Slaves that are not selected deliberately drive ready=1, error=1 and
//   garbage data.
// -----------------------------------------------------------------------------
module tb_apb_slave_splitter;

    localparam int NCH       = 4;
    localparam int ABITS     = 16;
    localparam int SBITS     = 12;
    localparam int SELB      = 2;
    localparam int TIMEOUT   = 8;
    localparam int LAT_LIMIT = 2 + TIMEOUT + 4;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              S_PSEL;
    logic              S_PENABLE;
    logic              S_PWRITE;
    logic [ABITS-1:0]  S_PADDR;
    logic [31:0]       S_PWDATA;
    logic [31:0]       S_PRDATA;
    logic              S_PREADY;
    logic              S_PSLVERR;
    logic [NCH-1:0]    M_PSEL;
    logic              M_PENABLE;
    logic              M_PWRITE;
    logic [SBITS-1:0]  M_PADDR;
    logic [31:0]       M_PWDATA;
    logic [32*NCH-1:0] M_PRDATA;
    logic [NCH-1:0]    M_PREADY;
    logic [NCH-1:0]    M_PSLVERR;
    logic              ERR;

    // Second instance: 3 channels, slaves always ready
    logic              psel3;
    logic [31:0]       sPrdata3;
    logic              sPready3;
    logic              sPslverr3;
    logic [2:0]        mPsel3;
    logic              mPenable3;
    logic              mPwrite3;
    logic [SBITS-1:0]  mPaddr3;
    logic [31:0]       mPwdata3;
    logic              err3;

    // Behavioural slave configuration for the current transfer
    int                slvWait;
    logic              slvErr;
    logic [31:0]       slvRdata;
    logic              slvStuck;
    int                accCnt;

    int                testCount = 0;
    int                failCount = 0;

    always #5 CLK = ~CLK;

    apb_slave_splitter #(
        .C_CHANNELS (NCH),
        .C_ADDR_BITS(ABITS),
        .C_SLOT_BITS(SBITS),
        .C_TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .S_PSEL   (S_PSEL),
        .S_PENABLE(S_PENABLE),
        .S_PWRITE (S_PWRITE),
        .S_PADDR  (S_PADDR),
        .S_PWDATA (S_PWDATA),
        .S_PRDATA (S_PRDATA),
        .S_PREADY (S_PREADY),
        .S_PSLVERR(S_PSLVERR),
        .M_PSEL   (M_PSEL),
        .M_PENABLE(M_PENABLE),
        .M_PWRITE (M_PWRITE),
        .M_PADDR  (M_PADDR),
        .M_PWDATA (M_PWDATA),
        .M_PRDATA (M_PRDATA),
        .M_PREADY (M_PREADY),
        .M_PSLVERR(M_PSLVERR),
        .ERR      (ERR)
    );

    apb_slave_splitter #(
        .C_CHANNELS (3),
        .C_ADDR_BITS(ABITS),
        .C_SLOT_BITS(SBITS),
        .C_TIMEOUT  (TIMEOUT)
    ) dut3 (
        .CLK      (CLK),
        .nRST     (nRST),
        .S_PSEL   (psel3),
        .S_PENABLE(S_PENABLE),
        .S_PWRITE (S_PWRITE),
        .S_PADDR  (S_PADDR),
        .S_PWDATA (S_PWDATA),
        .S_PRDATA (sPrdata3),
        .S_PREADY (sPready3),
        .S_PSLVERR(sPslverr3),
        .M_PSEL   (mPsel3),
        .M_PENABLE(mPenable3),
        .M_PWRITE (mPwrite3),
        .M_PADDR  (mPaddr3),
        .M_PWDATA (mPwdata3),
        .M_PRDATA ({3{32'h0BAD_F00D}}),
        .M_PREADY (3'b111),
        .M_PSLVERR(3'b000),
        .ERR      (err3)
    );

    // Count the ACCESS cycles the selected slave has already spent in the
    // current transfer.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            accCnt <= 0;
        end else if ((|M_PSEL) && M_PENABLE) begin
            accCnt <= accCnt + 1;
        end else begin
            accCnt <= 0;
        end
    end

    // Selected slave answers after slvWait wait states unless stuck. The
    // other slaves drive hostile values, so a wrong mux shows up.
    always_comb begin
        M_PREADY  = '0;
        M_PSLVERR = '0;
        M_PRDATA  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (M_PSEL[i]) begin
                M_PREADY[i]          = M_PENABLE && !slvStuck && (accCnt >= slvWait);
                M_PSLVERR[i]         = slvErr;
                M_PRDATA[32*i +: 32] = slvRdata;
            end else begin
                M_PREADY[i]          = 1'b1;
                M_PSLVERR[i]         = 1'b1;
                M_PRDATA[32*i +: 32] = 32'hDEAD_0000 | 32'(i);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Run one upstream transfer on the main instance and check it against
    // the address map and latency rules. Call it just after a rising edge.
    // It returns just after the edge that completes the transfer, with the
    // bus released.
    task automatic applyStimulus(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                                 input int waitSt, input logic slvE, input logic [31:0] rdata,
                                 input logic stuck);
        int          slotNum;
        int          upper;
        bit          mapped;
        bit          timedOut;
        int          expLat;
        logic        expErr;
        logic [31:0] expData;
        logic [3:0]  expSel;
        int          got;

        slotNum  = (int'(addr) >> SBITS) % (1 << SELB);
        upper    = int'(addr) >> (SBITS + SELB);
        mapped   = (upper == 0) && (slotNum < NCH);
        timedOut = mapped && (stuck || waitSt >= TIMEOUT);
        expLat   = !mapped ? 1 : (timedOut ? 2 + TIMEOUT : 3 + waitSt);
        expErr   = !mapped || timedOut || slvE;
        expData  = (mapped && !timedOut && !wr) ? rdata : 32'h0;
        expSel   = mapped ? 4'(1 << slotNum) : 4'h0;

        slvWait   = waitSt;
        slvErr    = slvE;
        slvRdata  = rdata;
        slvStuck  = stuck;
        S_PSEL    = 1'b1;
        S_PENABLE = 1'b0;
        S_PADDR   = addr;
        S_PWRITE  = wr;
        S_PWDATA  = wdata;
        got       = 0;

        for (int n = 1; n <= LAT_LIMIT && got == 0; n++) begin
            @(posedge CLK);
            #1;
            S_PENABLE = 1'b1;
            if (n == 1 && mapped) begin
                checkOutput("setup_sel", 64'({M_PSEL, M_PENABLE}), 64'({expSel, 1'b0}));
                checkOutput("setup_addr", 64'({M_PWRITE, M_PADDR}), 64'({wr, addr[11:0]}));
                checkOutput("setup_wdata", 64'(M_PWDATA), 64'(wdata));
            end
            if (n == 1 && !mapped) begin
                checkOutput("unmapped_sel", 64'(M_PSEL), 64'h0);
            end
            if (S_PREADY) begin
                got = n;
            end else if (n >= 2 && mapped) begin
                checkOutput("access_hold", 64'({M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA}),
                            64'({expSel, 1'b1, wr, addr[11:0], wdata}));
            end
        end

        checkOutput("latency", 64'(got), 64'(expLat));
        if (got != 0) begin
            checkOutput("resp_data", 64'(S_PRDATA), 64'(expData));
            checkOutput("resp_err", 64'({S_PSLVERR, ERR}), 64'({expErr, expErr}));
            checkOutput("resp_down_idle", 64'({M_PSEL, M_PENABLE, M_PADDR, M_PWDATA}), 64'h0);
        end
        @(posedge CLK);
        #1;
        checkOutput("resp_pulse", 64'({S_PREADY, ERR}), 64'h0);
        S_PSEL    = 1'b0;
        S_PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] rAddr;
        logic [31:0] rWdata;
        logic [31:0] rRdata;

        nRST      = 1'b0;
        S_PSEL    = 1'b0;
        psel3     = 1'b0;
        S_PENABLE = 1'b0;
        S_PWRITE  = 1'b0;
        S_PADDR   = '0;
        S_PWDATA  = '0;
        slvWait   = 0;
        slvErr    = 1'b0;
        slvRdata  = '0;
        slvStuck  = 1'b0;

        #3;
        checkOutput("reset_state", 64'({S_PREADY, S_PSLVERR, ERR, M_PSEL, M_PENABLE, M_PWRITE,
                                        |S_PRDATA, |M_PADDR, |M_PWDATA}), 64'h0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        $display("[TB] directed transfers");
        applyStimulus(16'h1004, 1'b1, 32'hA5A5_0001, 0, 1'b0, 32'h7777_7777, 1'b0);
        applyStimulus(16'h3010, 1'b0, 32'h0, 2, 1'b0, 32'h1234_5678, 1'b0);
        applyStimulus(16'h0000, 1'b0, 32'h0, 0, 1'b0, 32'h5555_AAAA, 1'b1);
        applyStimulus(16'h1008, 1'b1, 32'h0BEE_F00D, 1, 1'b0, 32'h0, 1'b0);
        applyStimulus(16'h2000, 1'b0, 32'h0, 0, 1'b1, 32'hFFFF_0000, 1'b0);
        applyStimulus(16'h0ABC, 1'b0, 32'h0, TIMEOUT - 1, 1'b0, 32'hCAFE_0007, 1'b0);
        applyStimulus(16'h4000, 1'b0, 32'h0, 0, 1'b0, 32'h1111_1111, 1'b0);

        // Unmapped slot on the 3-channel instance
        psel3     = 1'b1;
        S_PENABLE = 1'b0;
        S_PWRITE  = 1'b0;
        S_PADDR   = 16'h3000;
        @(posedge CLK);
        #1;
        checkOutput("ch3_unmapped_resp", 64'({mPsel3, sPready3, sPslverr3, err3}), 64'({3'b000, 3'b111}));
        checkOutput("ch3_unmapped_data", 64'(sPrdata3), 64'h0);
        S_PENABLE = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("ch3_unmapped_pulse", 64'({sPready3, err3}), 64'h0);
        psel3     = 1'b0;
        S_PENABLE = 1'b0;

        // Host drops PSEL during SETUP: downstream finishes, nothing upstream
        slvWait   = 2;
        slvErr    = 1'b1;
        slvStuck  = 1'b0;
        S_PSEL    = 1'b1;
        S_PADDR   = 16'h1020;
        @(posedge CLK);
        #1;
        S_PSEL = 1'b0;
        for (int n = 2; n <= 8; n++) begin
            @(posedge CLK);
            #1;
            checkOutput("abort_silent", 64'({S_PREADY, ERR}), 64'h0);
            if (n == 3) begin
                checkOutput("abort_continues", 64'({M_PSEL, M_PENABLE}), 64'({4'b0010, 1'b1}));
            end
        end
        checkOutput("abort_done", 64'(M_PSEL), 64'h0);

        $display("[TB] random back-to-back transfers");
        for (int t = 0; t < 100; t++) begin
            rAddr = 16'(($urandom_range(0, 3) << SBITS) | $urandom_range(0, 4095));
            if ($urandom_range(0, 7) == 0) begin
                rAddr[15:14] = 2'($urandom_range(1, 3));
            end
            rWdata = $urandom;
            rRdata = $urandom;
            applyStimulus(rAddr, 1'($urandom_range(0, 1)), rWdata, $urandom_range(0, 10),
                          1'($urandom_range(0, 5) == 0), rRdata, 1'b0);
        end

        // Asynchronous reset in the middle of an ACCESS on channel 2
        slvStuck  = 1'b1;
        S_PSEL    = 1'b1;
        S_PENABLE = 1'b0;
        S_PWRITE  = 1'b1;
        S_PADDR   = 16'h2020;
        S_PWDATA  = 32'h1357_9BDF;
        @(posedge CLK);
        #1;
        S_PENABLE = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        checkOutput("pre_reset_access", 64'({M_PSEL, M_PENABLE}), 64'({4'b0100, 1'b1}));
        #1;
        nRST = 1'b0;
        #1;
        checkOutput("async_reset", 64'({S_PREADY, S_PSLVERR, ERR, M_PSEL, M_PENABLE, M_PWRITE,
                                        |S_PRDATA, |M_PADDR, |M_PWDATA}), 64'h0);
        S_PSEL    = 1'b0;
        S_PENABLE = 1'b0;
        slvStuck  = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        applyStimulus(16'h0040, 1'b0, 32'h0, 0, 1'b0, 32'hC0DE_0040, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
